// File: rtl/imm_encode.sv
// Immediate encoder: range-checks a value against an immediate format, scatters it
// into the instruction's immediate fields, and emits the result through a 2-stage valid/ready pipe.
module imm_encode #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_value,
  input  logic [2:0]           in_imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [31:0] packed_word;
  logic        range_ok;
  logic [31:0] s1_instr_next;
  logic        s1_err_next;

  logic        s1_valid_reg;
  logic [31:0] s1_instr_reg;
  logic        s1_err_reg;
  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic        out_err_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  logic        s2_load;
  logic        s1_load;

  // Sign-extension checks: the discarded high bits must all match the top kept bit.
  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;
  assign sext12_ok = (&in_value[31:11]) | ~(|in_value[31:11]);
  assign sext13_ok = (&in_value[31:12]) | ~(|in_value[31:12]);
  assign sext21_ok = (&in_value[31:20]) | ~(|in_value[31:20]);

  always_comb begin
    packed_word = in_instr;
    range_ok    = 1'b0;
    case (in_imm_src)
      SRC_I: begin
        packed_word = {in_value[11:0], in_instr[19:0]};
        range_ok    = sext12_ok;
      end
      SRC_S: begin
        packed_word = {in_value[11:5], in_instr[24:12], in_value[4:0], in_instr[6:0]};
        range_ok    = sext12_ok;
      end
      SRC_B: begin
        packed_word = {in_value[12], in_value[10:5], in_instr[24:12],
                       in_value[4:1], in_value[11], in_instr[6:0]};
        range_ok    = sext13_ok & ~in_value[0];
      end
      SRC_J: begin
        packed_word = {in_value[20], in_value[10:1], in_value[11],
                       in_value[19:12], in_instr[11:0]};
        range_ok    = sext21_ok & ~in_value[0];
      end
      SRC_U: begin
        packed_word = {in_value[31:12], in_instr[11:0]};
        range_ok    = ~(|in_value[11:0]);
      end
      default: begin
        packed_word = in_instr;
        range_ok    = 1'b0;
      end
    endcase
    // Unrepresentable requests pass the base instruction through untouched.
    s1_instr_next = range_ok ? packed_word : in_instr;
    s1_err_next   = ~range_ok;
  end

  assign s2_load  = ~out_valid_reg | out_ready;
  assign s1_load  = ~s1_valid_reg | s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_instr_reg <= '0;
      s1_err_reg   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_instr_reg <= s1_instr_next;
        s1_err_reg   <= s1_err_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_err_reg   <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_instr_reg <= s1_instr_reg;
        out_err_reg   <= s1_err_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (out_valid_reg && out_ready && out_err_reg && (err_count_reg != ERR_MAX)) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_err   = out_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed vector table, latency/backpressure/saturation/reset
// sequences, and randomized traffic scored against a field-map encoder and extender model.
module tb_imm_encode;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_value;
  logic [2:0]  in_imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [W-1:0] err_count;

  imm_encode #(.ERR_CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_value(in_value), .in_imm_src(in_imm_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] value;
    logic [2:0]  src;
    logic [31:0] exp_instr;
    logic        exp_err;
  } req_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   model_cnt = 0;
  int   pops = 0;
  req_t q[$];
  logic last_in_ready;
  logic last_out_valid;
  logic [31:0] last_out_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] put(input logic [31:0] w, input int dlo, input int width,
                                      input logic [31:0] v, input int slo);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < width; k++) r[dlo+k] = v[slo+k];
    return r;
  endfunction

  // Reference encoder: numeric range rules plus a declarative field map.
  function automatic req_t model(input logic [31:0] ins, input logic [31:0] val, input logic [2:0] src);
    req_t r;
    int   sv;
    bit   ok;
    logic [31:0] w;
    sv = $signed(val);
    w  = ins;
    ok = 0;
    case (src)
      3'd0: begin ok = (sv >= -2048 && sv <= 2047); w = put(w, 20, 12, val, 0); end
      3'd1: begin ok = (sv >= -2048 && sv <= 2047);
                  w = put(w, 25, 7, val, 5); w = put(w, 7, 5, val, 0); end
      3'd2: begin ok = (sv >= -4096 && sv <= 4095 && (val % 2) == 0);
                  w = put(w, 31, 1, val, 12); w = put(w, 7, 1, val, 11);
                  w = put(w, 25, 6, val, 5);  w = put(w, 8, 4, val, 1); end
      3'd3: begin ok = (sv >= -(1 << 20) && sv < (1 << 20) && (val % 2) == 0);
                  w = put(w, 31, 1, val, 20); w = put(w, 12, 8, val, 12);
                  w = put(w, 20, 1, val, 11); w = put(w, 21, 10, val, 1); end
      3'd4: begin ok = ((val % 4096) == 0); w = put(w, 12, 20, val, 12); end
      default: ok = 0;
    endcase
    r.instr = ins; r.value = val; r.src = src;
    r.exp_instr = ok ? w : ins;
    r.exp_err   = !ok;
    return r;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: return {i[31:12], 12'b0};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive, observe handshakes, score pops, advance past the edge.
  task automatic cycle(input bit v, input req_t r, input bit ordy, output bit acc, output bit pop);
    req_t e;
    in_valid = v; in_instr = r.instr; in_value = r.value; in_imm_src = r.src; out_ready = ordy;
    #1;
    last_in_ready = in_ready; last_out_valid = out_valid; last_out_instr = out_instr;
    acc = v && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      pops++;
      if (q.size() == 0) begin
        chk("unexpected_pop", 32'(out_valid), 32'h0);
      end else begin
        e = q.pop_front();
        $display("pop %0d: src=%0d value=%h instr=%h err=%0d count=%0d",
                 pops, e.src, e.value, out_instr, out_err, err_count);
        chk("out_instr", out_instr, e.exp_instr);
        chk("out_err", 32'(out_err), 32'(e.exp_err));
        chk("err_count", 32'(err_count), 32'(model_cnt));
        if (!e.exp_err) chk("roundtrip", ext(out_instr, e.src), e.value);
        if (e.exp_err && model_cnt < (1 << W) - 1) model_cnt++;
      end
    end
    if (acc) q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic send(input req_t r, input bit ordy);
    bit acc, pop;
    int n;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, r, ordy, acc, pop);
      n++;
    end
    if (!acc) chk("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic drain();
    bit acc, pop;
    req_t idle;
    idle = model(32'h0, 32'h0, 3'd0);
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle(1'b0, idle, 1'b1, acc, pop);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  req_t tbl[10];
  req_t bp[4];

  initial begin
    bit acc, pop;
    req_t idle;
    logic [31:0] stall_instr;
    int idx;

    tbl[0] = '{32'h00000013, 32'hFFFFF800, 3'd0, 32'h80000013, 1'b0};
    tbl[1] = '{32'h00002023, 32'hFFFFFFFC, 3'd1, 32'hFE002E23, 1'b0};
    tbl[2] = '{32'h00000013, 32'h00000800, 3'd0, 32'h00000013, 1'b1};
    tbl[3] = '{32'h00000063, 32'hFFFFFFFC, 3'd2, 32'hFE000EE3, 1'b0};
    tbl[4] = '{32'h000000EF, 32'h00000008, 3'd3, 32'h008000EF, 1'b0};
    tbl[5] = '{32'h00000063, 32'h00000003, 3'd2, 32'h00000063, 1'b1};
    tbl[6] = '{32'h000000EF, 32'h00100000, 3'd3, 32'h000000EF, 1'b1};
    tbl[7] = '{32'h000000B7, 32'h12345000, 3'd4, 32'h123450B7, 1'b0};
    tbl[8] = '{32'h000000B7, 32'h12345001, 3'd4, 32'h000000B7, 1'b1};
    tbl[9] = '{32'h12345678, 32'h00000004, 3'd7, 32'h12345678, 1'b1};
    idle = model(32'h0, 32'h0, 3'd0);

    rst = 1'b1; in_valid = 0; in_instr = 0; in_value = 0; in_imm_src = 0; out_ready = 0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Directed table at full throughput.
    for (int i = 0; i < 10; i++) send(tbl[i], 1'b1);
    drain();

    // Latency: accept at edge N, visible after N+1, consumed at N+2.
    cycle(1'b1, tbl[0], 1'b1, acc, pop);
    chk("lat_after_n", 32'(out_valid), 32'd0);
    cycle(1'b0, idle, 1'b1, acc, pop);
    chk("lat_after_n1", 32'(out_valid), 32'd1);
    cycle(1'b0, idle, 1'b1, acc, pop);
    chk("lat_pop_n2", 32'(pop), 32'd1);

    // Backpressure: 4 requests, 5 stalled cycles, then drain one per cycle.
    for (int i = 0; i < 4; i++) bp[i] = model($urandom, 32'(i * 4 + 16), 3'(i));
    idx = 0; stall_instr = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(idx < 4, bp[idx < 4 ? idx : 3], 1'b0, acc, pop);
      if (idx >= 2) chk("bp_in_ready", 32'(last_in_ready), 32'd0);
      if (c == 2) stall_instr = last_out_instr;
      if (c > 2) chk("bp_stable", last_out_instr, stall_instr);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    for (int c = 0; c < 6; c++) begin
      cycle(idx < 4, bp[idx < 4 ? idx : 3], 1'b1, acc, pop);
      if (c < 4) chk("bp_pop_each_cycle", 32'(pop), 32'd1);
      if (acc) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd4);
    drain();

    // Saturation with a 2-bit counter.
    for (int i = 0; i < 5; i++) send(model(32'h00000013, 32'h00010000, 3'd0), 1'b1);
    drain();
    chk("sat_err_count", 32'(err_count), 32'd3);

    // Reset with two requests in flight.
    send(tbl[1], 1'b0);
    send(tbl[2], 1'b0);
    in_valid = 0;
    #1; rst = 1'b1; #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    q.delete(); model_cnt = 0;
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, idle, 1'b1, acc, pop);
      chk("postrst_no_output", 32'(last_out_valid), 32'd0);
    end

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] val;
      int mode;
      mode = $urandom_range(0, 3);
      case (mode)
        0: val = $urandom;
        1: val = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: val = 32'(int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20));
        default: val = $urandom & 32'hFFFFF000;
      endcase
      if ($urandom_range(0, 1) == 1) val[0] = 1'b0;
      cycle($urandom_range(0, 3) != 0, model($urandom, val, 3'($urandom_range(0, 7))),
            $urandom_range(0, 3) != 0, acc, pop);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_encode.md
# imm_encode

Immediate encoder: the inverse of the datapath's immediate extender. It takes a base instruction word, a 32-bit signed/unsigned value and an immediate-format code. It range-checks the value, scatters its bits into the format's instruction fields, and emits the patched instruction through a 2-stage valid/ready pipeline. It sits on the program-loader / debug-patch path, ahead of instruction memory writes, and flags values the format cannot represent.

## Interface
- ERR_CNT_W, 16, width of the saturating error counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at a clk edge
- in_instr  input  32  base instruction; non-immediate bits are passed through
- in_value  input  32  immediate value, two's complement
- in_imm_src  input  3  format code: 000 I, 001 S, 010 B, 011 J, 100 U (same codes as the extender)
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready at a clk edge
- out_instr  output  32  patched instruction
- out_err  output  1  value not representable, or code illegal
- err_count  output  ERR_CNT_W  count of consumed results with out_err=1; saturates

## Operation
- Field placement (v = in_value, i = instruction). All other bits of i are taken from in_instr:
  - I: i[31:20]=v[11:0].
  - S: i[31:25]=v[11:5]; i[11:7]=v[4:0].
  - B: i[31]=v[12]; i[7]=v[11]; i[30:25]=v[10:5]; i[11:8]=v[4:1].
  - J: i[31]=v[20]; i[19:12]=v[19:12]; i[20]=v[11]; i[30:21]=v[10:1].
  - U: i[31:12]=v[31:12].
- Representability. Any failure sets err:
  - I/S: v[31:11] all equal.
  - B: v[31:12] all equal and v[0]=0.
  - J: v[31:20] all equal and v[0]=0.
  - U: v[11:0]=0.
  - Codes 101–111 are always err.
- On err, out_instr = in_instr unmodified and out_err=1.
- Round-trip property: for every non-err result, extending out_instr[31:7] with the same code returns in_value.
- Stage 1 register holds the range-check result, the field-packed word and the err bit. Stage 2 register holds out_instr/out_err/out_valid.
- Stage advance rules:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || (stage 2 loads). This is a combinational path from out_ready, which is permitted.
- Stage 2 holds contents stable while out_valid && !out_ready.
- err_count increments by 1 on each output handshake with out_err=1. It holds at 2^ERR_CNT_W−1.

## Timing
- Reset values (asynchronous): in_ready=1, s1_valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1 and is consumable at edge N+2.
- Throughput: 1 request per cycle while out_ready=1.
- Full pipeline (both stages valid) with out_ready=0: in_ready=0.
- Simultaneous output pop and input push at full: both happen at the same edge, with no bubble and no loss.
- Order is strictly FIFO.
- Reset mid-operation discards all in-flight requests. err_count clears.

## Test plan
- I/S: (0x00000013, 0xFFFFF800, I) -> 0x80000013, err 0. (0x00002023, 0xFFFFFFFC, S) -> 0xFE002E23. (0x00000013, 0x00000800, I) -> 0x00000013, err 1, err_count 1.
- B/J: (0x00000063, 0xFFFFFFFC, B) -> 0xFE000EE3. (0x000000EF, 0x00000008, J) -> 0x008000EF. (0x00000063, 0x00000003, B) -> err. (0x000000EF, 0x00100000, J) -> err.
- U/illegal: (0x000000B7, 0x12345000, U) -> 0x123450B7. value 0x12345001 -> err. code 111 -> err, out_instr = in_instr.
- Backpressure: stream 4 requests with out_ready=0 for 5 cycles. Required: in_ready drops after 2 accepts, out_instr stable while stalled, then all 4 emerge in order, 1 per cycle.
- Saturation/reset: ERR_CNT_W=2, 5 err results consumed -> err_count=3. Assert rst with 2 requests in flight -> out_valid=0 and err_count=0 immediately, no stale output after release.
- Randomized round-trip: random values/codes through the extender model -> every non-err result reproduces in_value. Every err matches the range rules.
